// File: rtl/csa_word_sequencer.sv
// Nibble-serial word adder built around one shared 4-bit carry-select adder cell.
// carry_select_adder: purpose 4-bit add, latency combinational, backpressure none.

// Purpose: 4-bit carry-select adder; low pair ripples, high pair is precomputed for both carries.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module carry_select_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  logic c1, c2;
  logic h0_c0, h1_c0, h0_c1, h1_c1;
  logic [1:0] hs_c0, hs_c1;

  assign {c1, sum[0]} = fa(a[0], b[0], cin);
  assign {c2, sum[1]} = fa(a[1], b[1], c1);

  // Upper pair evaluated speculatively for both incoming carries, then selected by c2.
  assign {h0_c0, hs_c0[0]} = fa(a[2], b[2], 1'b0);
  assign {h1_c0, hs_c0[1]} = fa(a[3], b[3], h0_c0);
  assign {h0_c1, hs_c1[0]} = fa(a[2], b[2], 1'b1);
  assign {h1_c1, hs_c1[1]} = fa(a[3], b[3], h0_c1);

  assign sum[3:2] = c2 ? hs_c1 : hs_c0;
  assign cout     = c2 ? h1_c1 : h1_c0;

endmodule

// Purpose: WIDTH-bit a+b+cin computed one nibble per cycle through a single shared adder.
// Latency: out_valid rises WIDTH/4 edges after the acceptance edge.
// Backpressure: result held in DONE until out_ready; in_ready only while idle.
module csa_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic             last;
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cout;

  assign last  = (idx == IW'(NIB - 1));
  assign nib_a = a_q[{idx, 2'b00} +: 4];
  assign nib_b = b_q[{idx, 2'b00} +: 4];

  carry_select_adder u_csa (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Working accumulator with the current nibble merged in; published to sum only on the last step.
  always_comb begin
    acc_nxt = acc_q;
    acc_nxt[{idx, 2'b00} +: 4] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        ADD: begin
          acc_q   <= acc_nxt;
          carry_q <= nib_cout;
          if (last) begin
            idx  <= '0;
            sum  <= acc_nxt;
            cout <= nib_cout;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Bench for csa_word_sequencer: directed table, multi-cycle corner sequences, randomized ops at WIDTH 16 and 8.
module tb_csa_word_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin;
  logic        out_ready;
  logic        w8;

  logic        rdy16, ov16, co16, rdy8, ov8, co8;
  logic [15:0] sum16;
  logic [7:0]  sum8;

  logic        in_ready_m, out_valid_m, cout_m;
  logic [15:0] sum_m;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  csa_word_sequencer #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~w8), .in_ready(rdy16),
    .a(a), .b(b), .cin(cin), .out_valid(ov16), .out_ready(out_ready),
    .sum(sum16), .cout(co16)
  );

  csa_word_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & w8), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov8), .out_ready(out_ready),
    .sum(sum8), .cout(co8)
  );

  assign in_ready_m  = w8 ? rdy8 : rdy16;
  assign out_valid_m = w8 ? ov8 : ov16;
  assign cout_m      = w8 ? co8 : co16;
  assign sum_m       = w8 ? {8'h00, sum8} : sum16;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Runs one operation from a negedge; returns result, edges to out_valid, and hold stability.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input int hold, input bit junk,
                        output logic [15:0] rs, output logic rc, output int lat, output bit stable);
    int t = 0;
    while (!in_ready_m && t < 50) begin @(negedge clk); t++; end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    if (junk) begin a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'($urandom); end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid_m && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
      if (junk) begin a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'($urandom); end
    end
    rs = sum_m; rc = cout_m; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      if (!out_valid_m || sum_m !== rs || cout_m !== rc) stable = 1'b0;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    int          hold;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [15:0] rs;
    logic        rc;
    int          lat;
    bit          stable;
    bit          seen;

    vt[0] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
    vt[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 5};
    vt[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
    vt[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 2};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};

    // Reset with a request pending: it must not be taken.
    w8 = 1'b0; rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("reset_in_ready16", 64'(rdy16), 64'd1);
    chk("reset_out_valid16", 64'(ov16), 64'd0);
    chk("reset_sum16", 64'(sum16), 64'd0);
    chk("reset_cout16", 64'(co16), 64'd0);
    chk("reset_in_ready8", 64'(rdy8), 64'd1);
    chk("reset_out_valid8", 64'(ov8), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].hold, 1'b0, rs, rc, lat, stable);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vt[i].s));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vt[i].c));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      if (vt[i].hold > 0) chk($sformatf("vec%0d_hold_stable", i), 64'(stable), 64'd1);
      chk($sformatf("vec%0d_in_ready_after", i), 64'(in_ready_m), 64'd1);
    end

    // Reset pulse at nibble step 2 with a request asserted on the reset edge.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("abort_in_ready", 64'(rdy16), 64'd1);
    chk("abort_out_valid", 64'(ov16), 64'd0);
    chk("abort_sum", 64'(sum16), 64'd0);
    chk("abort_cout", 64'(co16), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (ov16 || !rdy16) seen = 1'b1;
    end
    chk("abort_no_stale_valid", 64'(seen), 64'd0);

    // Second request held on in_valid throughout the first operation.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 16'h0001; b = 16'h0001;
    lat = 0;
    while (!ov16 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("held_req_latency1", 64'(lat), 64'd4);
    chk("held_req_sum1", 64'(sum16), 64'h3333);
    rs = sum16; stable = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (!ov16 || sum16 !== rs) stable = 1'b0;
    end
    chk("held_req_stable1", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("held_req_idle", 64'(rdy16), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("held_req_accepted", 64'(rdy16), 64'd0);
    lat = 0;
    while (!ov16 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("held_req_latency2", 64'(lat), 64'd4);
    chk("held_req_sum2", 64'(sum16), 64'h0002);
    chk("held_req_cout2", 64'(co16), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;

    // Random operations against plain arithmetic, with junk on the inputs while busy.
    for (int w = 0; w < 2; w++) begin
      int          wid;
      logic [63:0] mask;
      w8   = (w == 1);
      wid  = w8 ? 8 : 16;
      mask = w8 ? 64'hFF : 64'hFFFF;
      for (int n = 0; n < 200; n++) begin
        logic [15:0] ra, rb;
        logic        rcin;
        logic [63:0] tot;
        ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
        tot = (64'(ra) & mask) + (64'(rb) & mask) + 64'(rcin);
        run_op(ra, rb, rcin, $urandom_range(0, 3), 1'b1, rs, rc, lat, stable);
        chk($sformatf("rand_w%0d_%0d_sum", wid, n), 64'(rs), tot & mask);
        chk($sformatf("rand_w%0d_%0d_cout", wid, n), 64'(rc), (tot >> wid) & 64'd1);
        chk($sformatf("rand_w%0d_%0d_latency", wid, n), 64'(lat), 64'(wid / 4));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", pass_cnt, total);
    $fatal(1, "watchdog");
  end

endmodule
